// File: rtl/pfs_fetch_queue_pkg.sv
// Shared types and constants for the pre-IF fetch queue.
package pfs_fetch_queue_pkg;

   localparam int unsigned PFS_TO_FS_BUS_WD = 64;
   localparam int unsigned PC_W             = 32;
   localparam int unsigned INST_W           = 32;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'hbfc00000;
   localparam logic [31:0] EX_ENTRY         = 32'hbfc00380;

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } issue_state_e;

   // Head entry handed to IF: {inst, pc}
   typedef struct packed {
      logic [INST_W-1:0] inst;
      logic [PC_W-1:0]   pc;
   } pfs_to_fs_bus_t;

endpackage

// File: rtl/pfs_slot_fifo.sv
// In-order slot buffer: allocate on request accept, fill on response, pop to IF.
module pfs_slot_fifo
   import pfs_fetch_queue_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         resetn,
   input  logic                         flush,
   input  logic                         alloc_en,
   input  logic [PC_W-1:0]              alloc_pc,
   input  logic                         fill_en,
   input  logic [INST_W-1:0]            fill_inst,
   input  logic                         pop_en,
   output logic                         head_filled,
   output pfs_to_fs_bus_t               head_entry,
   output logic [$clog2(DEPTH+1)-1:0]   used,
   output logic [$clog2(DEPTH+1)-1:0]   unfilled
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [PC_W-1:0]   pc_q   [DEPTH];
   logic [INST_W-1:0] inst_q [DEPTH];
   logic [DEPTH-1:0]  filled_q;
   logic [PW-1:0]     alloc_ptr;
   logic [PW-1:0]     fill_ptr;
   logic [PW-1:0]     head_ptr;

   // Slot storage, pointers and occupancy counts; flush empties every slot
   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            pc_q[PW'(i)]   <= '0;
            inst_q[PW'(i)] <= '0;
         end
         filled_q  <= '0;
         alloc_ptr <= '0;
         fill_ptr  <= '0;
         head_ptr  <= '0;
         used      <= '0;
         unfilled  <= '0;
      end else if (flush) begin
         filled_q  <= '0;
         alloc_ptr <= '0;
         fill_ptr  <= '0;
         head_ptr  <= '0;
         used      <= '0;
         unfilled  <= '0;
      end else begin
         if (alloc_en) begin
            pc_q[alloc_ptr]     <= alloc_pc;
            filled_q[alloc_ptr] <= 1'b0;
            alloc_ptr           <= alloc_ptr + PW'(1);
         end
         if (fill_en) begin
            inst_q[fill_ptr]   <= fill_inst;
            filled_q[fill_ptr] <= 1'b1;
            fill_ptr           <= fill_ptr + PW'(1);
         end
         if (pop_en) begin
            filled_q[head_ptr] <= 1'b0;
            head_ptr           <= head_ptr + PW'(1);
         end
         used     <= used + CW'(alloc_en) - CW'(pop_en);
         unfilled <= unfilled + CW'(alloc_en) - CW'(fill_en);
      end
   end

   assign head_filled = filled_q[head_ptr];
   assign head_entry  = '{inst: inst_q[head_ptr], pc: pc_q[head_ptr]};

endmodule

// File: rtl/pfs_fetch_queue.sv
// Pre-IF fetch queue: keeps up to DEPTH in-order fetches in flight, cancels by counting on redirect.
module pfs_fetch_queue
   import pfs_fetch_queue_pkg::*;
#(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter logic [31:0] PC_INC   = 32'h4
) (
   input  logic                        clk,
   input  logic                        resetn,
   input  logic                        fs_allowin,
   output logic                        pfs_to_fs_valid,
   output logic [PFS_TO_FS_BUS_WD-1:0] pfs_to_fs_bus,
   input  logic                        redirect_valid,
   input  logic [31:0]                 redirect_pc,
   input  logic                        stall_req,
   output logic                        inst_ram_req,
   output logic [31:0]                 inst_ram_addr,
   input  logic                        inst_ram_addr_ok,
   input  logic [31:0]                 inst_ram_rdata,
   input  logic                        inst_ram_data_ok,
   output logic                        inst_ram_data_waiting
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned SW = CW + 1;

   issue_state_e   state_q, state_d;
   logic           stale_q, stale_d;
   logic [CW-1:0]  cancel_q, cancel_d;
   logic [31:0]    next_pc_q, next_pc_d;
   logic [31:0]    addr_q, addr_d;

   logic [CW-1:0]  used;
   logic [CW-1:0]  unfilled;
   logic           head_filled;
   pfs_to_fs_bus_t head_entry;

   logic           accept;
   logic           drop;
   logic           fill_hit;
   logic           consumed;
   logic           outstanding;
   logic           credit_ok;

   assign accept      = (state_q == REQ) && inst_ram_addr_ok;
   assign drop        = inst_ram_data_ok && (cancel_q != '0);
   assign fill_hit    = inst_ram_data_ok && (cancel_q == '0) && (unfilled != '0);
   assign consumed    = drop || fill_hit;
   assign outstanding = (unfilled != '0) || (cancel_q != '0);
   assign credit_ok   = (SW'(used) + SW'(cancel_q)) < SW'(DEPTH);

   // State and bookkeeping registers
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q   <= IDLE;
         stale_q   <= 1'b0;
         cancel_q  <= '0;
         next_pc_q <= RESET_PC;
         addr_q    <= '0;
      end else begin
         state_q   <= state_d;
         stale_q   <= stale_d;
         cancel_q  <= cancel_d;
         next_pc_q <= next_pc_d;
         addr_q    <= addr_d;
      end
   end

   // Issue FSM, next PC and cancel accounting; redirect overrides the sequential PC
   always_comb begin
      state_d   = state_q;
      stale_d   = stale_q;
      cancel_d  = cancel_q;
      next_pc_d = next_pc_q;
      addr_d    = addr_q;

      case (state_q)
         IDLE: begin
            if (!stall_req && !redirect_valid && credit_ok) begin
               state_d = REQ;
               addr_d  = next_pc_q;
            end
         end
         REQ: begin
            if (inst_ram_addr_ok) begin
               state_d = IDLE;
               stale_d = 1'b0;
               if (!stale_q) begin
                  next_pc_d = next_pc_q + PC_INC;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (redirect_valid) begin
         cancel_d  = CW'(SW'(cancel_q) + SW'(unfilled) + SW'(accept) - SW'(consumed));
         next_pc_d = redirect_pc;
         if ((state_q == REQ) && !inst_ram_addr_ok) begin
            stale_d = 1'b1;
         end
      end else begin
         cancel_d = CW'(SW'(cancel_q) + SW'(accept && stale_q) - SW'(drop));
      end
   end

   pfs_slot_fifo #(
      .DEPTH (DEPTH)
   ) u_slot_fifo (
      .clk         (clk),
      .resetn      (resetn),
      .flush       (redirect_valid),
      .alloc_en    (accept && !stale_q && !redirect_valid),
      .alloc_pc    (addr_q),
      .fill_en     (fill_hit && !redirect_valid),
      .fill_inst   (inst_ram_rdata),
      .pop_en      (pfs_to_fs_valid && fs_allowin),
      .head_filled (head_filled),
      .head_entry  (head_entry),
      .used        (used),
      .unfilled    (unfilled)
   );

   assign inst_ram_req          = (state_q == REQ);
   assign inst_ram_addr         = addr_q;
   assign pfs_to_fs_valid       = head_filled && !redirect_valid;
   assign pfs_to_fs_bus         = head_entry;
   assign inst_ram_data_waiting = outstanding;

`ifndef SYNTHESIS
   // Bus protocol and slot-credit sanity
   always_ff @(posedge clk) begin
      if (resetn) begin
         assert (!inst_ram_data_ok || outstanding);
         assert ((SW'(used) + SW'(cancel_q) + SW'(stale_q)) <= SW'(DEPTH));
      end
   end
`endif

endmodule

// File: tb/tb_pfs_fetch_queue.sv
// Scoreboard bench for pfs_fetch_queue with a latency-programmable inst RAM model.
module tb_pfs_fetch_queue;
   import pfs_fetch_queue_pkg::*;

   logic        clk;
   logic        resetn;
   logic        fs_allowin;
   logic        pfs_to_fs_valid;
   logic [63:0] pfs_to_fs_bus;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        stall_req;
   logic        inst_ram_req;
   logic [31:0] inst_ram_addr;
   logic        inst_ram_addr_ok;
   logic [31:0] inst_ram_rdata;
   logic        inst_ram_data_ok;
   logic        inst_ram_data_waiting;

   pfs_fetch_queue dut (
      .clk                   (clk),
      .resetn                (resetn),
      .fs_allowin            (fs_allowin),
      .pfs_to_fs_valid       (pfs_to_fs_valid),
      .pfs_to_fs_bus         (pfs_to_fs_bus),
      .redirect_valid        (redirect_valid),
      .redirect_pc           (redirect_pc),
      .stall_req             (stall_req),
      .inst_ram_req          (inst_ram_req),
      .inst_ram_addr         (inst_ram_addr),
      .inst_ram_addr_ok      (inst_ram_addr_ok),
      .inst_ram_rdata        (inst_ram_rdata),
      .inst_ram_data_ok      (inst_ram_data_ok),
      .inst_ram_data_waiting (inst_ram_data_waiting)
   );

   typedef struct {
      logic [31:0] addr;
      int unsigned due;
   } ram_req_t;

   ram_req_t       ram_q[$];
   pfs_to_fs_bus_t exp_q[$];

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;
   int unsigned cyc     = 0;
   int unsigned n_accept;
   int unsigned n_pop;
   int unsigned g_lat;
   logic        g_allow;
   logic        g_stall;
   logic        g_aok;
   logic [31:0] exp_pc;
   logic        stale_pend;
   logic        hold_prev;
   logic [31:0] hold_addr;
   logic        want_first;
   logic [31:0] first_pc;
   logic        both_arm;
   logic        both_hit;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return a * 32'h9e3779b1 + 32'h00001357;
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      resetn           = 1'b0;
      redirect_valid   = 1'b0;
      redirect_pc      = 32'h0;
      stall_req        = 1'b0;
      fs_allowin       = 1'b0;
      inst_ram_addr_ok = 1'b0;
      inst_ram_data_ok = 1'b0;
      inst_ram_rdata   = 32'h0;
      @(negedge clk);
      @(negedge clk);
      #1;
      check("rst_req",     64'(inst_ram_req), 64'(0));
      check("rst_valid",   64'(pfs_to_fs_valid), 64'(0));
      check("rst_bus",     pfs_to_fs_bus, 64'(0));
      check("rst_waiting", 64'(inst_ram_data_waiting), 64'(0));
      ram_q.delete();
      exp_q.delete();
      exp_pc     = 32'hbfc00000;
      stale_pend = 1'b0;
      hold_prev  = 1'b0;
      hold_addr  = 32'h0;
      want_first = 1'b0;
      first_pc   = 32'h0;
      both_arm   = 1'b0;
      both_hit   = 1'b0;
      n_accept   = 0;
      n_pop      = 0;
      g_stall    = 1'b0;
      g_allow    = 1'b1;
      g_aok      = 1'b1;
      g_lat      = 1;
   endtask

   // One clock: drive at negedge, sample 1 ns later, account for the handshakes of the coming edge
   task automatic cycle(input logic redir, input logic [31:0] rpc);
      logic           dok;
      logic           rd;
      logic           acc;
      logic           pop;
      pfs_to_fs_bus_t e;
      @(negedge clk);
      cyc++;
      resetn = 1'b1;
      dok = (ram_q.size() > 0) && (ram_q[0].due <= cyc);
      rd  = redir;
      if (both_arm && dok && inst_ram_req && g_aok) begin
         rd       = 1'b1;
         both_arm = 1'b0;
         both_hit = 1'b1;
      end
      redirect_valid   = rd;
      redirect_pc      = rpc;
      stall_req        = g_stall;
      fs_allowin       = g_allow;
      inst_ram_addr_ok = g_aok;
      inst_ram_data_ok = dok;
      inst_ram_rdata   = dok ? inst_of(ram_q[0].addr) : 32'h0;
      #1;
      check("data_waiting", 64'(inst_ram_data_waiting), 64'(ram_q.size() != 0));
      if (hold_prev) begin
         check("req_held",  64'(inst_ram_req), 64'(1));
         check("addr_held", 64'(inst_ram_addr), 64'(hold_addr));
      end
      if (rd) check("valid_on_redirect", 64'(pfs_to_fs_valid), 64'(0));
      acc = inst_ram_req && g_aok;
      pop = pfs_to_fs_valid && g_allow;
      if (dok) ram_q.delete(0);
      if (pop) begin
         n_pop++;
         check("pop_expected", 64'(exp_q.size() != 0), 64'(1));
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("pop_entry", pfs_to_fs_bus, 64'(e));
         end
         if (want_first) begin
            first_pc   = pfs_to_fs_bus[31:0];
            want_first = 1'b0;
         end
      end
      if (acc) begin
         n_accept++;
         ram_q.push_back('{addr: inst_ram_addr, due: cyc + g_lat});
         if (!stale_pend && !rd) begin
            check("req_addr", 64'(inst_ram_addr), 64'(exp_pc));
            exp_q.push_back('{inst: inst_of(inst_ram_addr), pc: inst_ram_addr});
            exp_pc = exp_pc + 32'h4;
         end
         stale_pend = 1'b0;
      end
      hold_prev = inst_ram_req && !g_aok;
      hold_addr = inst_ram_addr;
      if (rd) begin
         exp_q.delete();
         exp_pc     = rpc;
         want_first = 1'b1;
         if (inst_ram_req && !g_aok) stale_pend = 1'b1;
      end
   endtask

   initial begin
      int unsigned p0;
      int unsigned a0;

      // Straight-line fetch, one-cycle RAM, IF always ready
      do_reset();
      repeat (40) cycle(1'b0, 32'h0);
      check("t1_pops", 64'(n_pop >= 15), 64'(1));

      // Slow RAM and IF blocked: credit stops issue at DEPTH
      do_reset();
      g_lat   = 5;
      g_allow = 1'b0;
      repeat (40) cycle(1'b0, 32'h0);
      check("t2_accepts", 64'(n_accept), 64'(4));
      check("t2_req_low", 64'(inst_ram_req), 64'(0));
      g_allow = 1'b1;
      repeat (40) cycle(1'b0, 32'h0);
      check("t2_drain",  64'(n_pop >= 4), 64'(1));
      check("t2_resume", 64'(n_accept > 4), 64'(1));

      // Redirect with three unfilled slots
      do_reset();
      g_lat = 8;
      for (int i = 0; i < 20 && n_accept < 3; i++) cycle(1'b0, 32'h0);
      check("t3_issued", 64'(n_accept), 64'(3));
      cycle(1'b1, 32'h80001000);
      repeat (40) cycle(1'b0, 32'h0);
      check("t3_first_pc", 64'(first_pc), 64'(32'h80001000));

      // Redirect while a request is held without addr_ok
      do_reset();
      for (int i = 0; i < 30 && n_accept < 4; i++) cycle(1'b0, 32'h0);
      check("t4_issued", 64'(n_accept), 64'(4));
      g_aok = 1'b0;
      repeat (2) cycle(1'b0, 32'h0);
      check("t4_req",  64'(inst_ram_req), 64'(1));
      check("t4_addr", 64'(inst_ram_addr), 64'(32'hbfc00010));
      cycle(1'b1, 32'h80002000);
      repeat (3) cycle(1'b0, 32'h0);
      check("t4_addr_after", 64'(inst_ram_addr), 64'(32'hbfc00010));
      g_aok = 1'b1;
      repeat (30) cycle(1'b0, 32'h0);
      check("t4_first_pc", 64'(first_pc), 64'(32'h80002000));

      // Redirect coinciding with data_ok and addr_ok
      do_reset();
      g_lat    = 2;
      both_arm = 1'b1;
      for (int i = 0; i < 40 && !both_hit; i++) cycle(1'b0, 32'h80003000);
      check("t5_collision", 64'(both_hit), 64'(1));
      repeat (30) cycle(1'b0, 32'h80003000);
      check("t5_first_pc", 64'(first_pc), 64'(32'h80003000));

      // Stall in IDLE: buffered entries still drain, stream resumes in order
      do_reset();
      g_allow = 1'b0;
      repeat (12) cycle(1'b0, 32'h0);
      g_stall = 1'b1;
      g_allow = 1'b1;
      p0 = n_pop;
      cycle(1'b0, 32'h0);
      a0 = n_accept;
      for (int i = 0; i < 9; i++) begin
         cycle(1'b0, 32'h0);
         check("t6_no_req", 64'(inst_ram_req), 64'(0));
      end
      check("t6_delivered", 64'(n_pop - p0 >= 2), 64'(1));
      g_stall = 1'b0;
      repeat (30) cycle(1'b0, 32'h0);
      check("t6_resume", 64'(n_accept > a0), 64'(1));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
